clock_counter: RTL and testbench

CLOCK_COUNTER -- requirements
Module: clock_counter

---
 rtl/clock_counter.sv | 121 ++++++++++++
 tb/tb_clock_counter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_counter.sv
// clock_counter: 12-hour time-of-day clock with AM/PM flag and a set mode.
// A prescaler divides clk down to a one-second strobe. Each strobe advances
// secs -> mins -> hrs through a carry chain. In set mode timekeeping is halted
// and each rising edge of inc bumps one selected field, with no carry into the
// other fields. All outputs are plain binary values.
module clock_counter #(
    parameter int TICKS_PER_SEC = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_en,
    input  logic [1:0] set_sel,
    input  logic       inc,
    output logic [5:0] hrs,
    output logic [5:0] mins,
    output logic [5:0] secs,
    output logic       ampm,
    output logic       tick
);

    localparam int              PW       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(TICKS_PER_SEC - 1);

    localparam logic [1:0] SEL_HRS  = 2'd0;
    localparam logic [1:0] SEL_MINS = 2'd1;
    localparam logic [1:0] SEL_SECS = 2'd2;

    logic [PW-1:0] r_prescale;
    logic [5:0]    r_hrs;
    logic [5:0]    r_mins;
    logic [5:0]    r_secs;
    logic          r_ampm;
    logic          r_tick;
    logic          r_inc_q;

    logic          w_strobe;
    logic          w_inc_pulse;
    logic [5:0]    w_secs_next;
    logic [5:0]    w_mins_next;
    logic [5:0]    w_hrs_next;
    logic          w_secs_wrap;
    logic          w_mins_wrap;
    logic          w_ampm_flip;

    // The strobe is gated by set_en, so entering set mode on the terminal
    // prescaler count suppresses that second entirely.
    assign w_strobe    = ~set_en & (r_prescale == PRE_LAST);
    assign w_inc_pulse = inc & ~r_inc_q;

    // The same wrap rules serve both the run carry chain and set-mode bumps.
    assign w_secs_wrap = (r_secs == 6'd59);
    assign w_mins_wrap = (r_mins == 6'd59);
    assign w_secs_next = w_secs_wrap ? 6'd0 : r_secs + 6'd1;
    assign w_mins_next = w_mins_wrap ? 6'd0 : r_mins + 6'd1;
    assign w_hrs_next  = (r_hrs == 6'd12) ? 6'd1 : r_hrs + 6'd1;
    assign w_ampm_flip = (r_hrs == 6'd11);

    // Prescaler: counts cycles in run mode and is held at zero in set mode,
    // so the first second after leaving set mode is a full period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prescale <= '0;
        end else if (set_en || (r_prescale == PRE_LAST)) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + 1'b1;
        end
    end

    // Registered tick (high in the cycle after the strobe edge) and the inc
    // history bit, which tracks inc in every mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick  <= 1'b0;
            r_inc_q <= 1'b0;
        end else begin
            r_tick  <= w_strobe;
            r_inc_q <= inc;
        end
    end

    // Time fields: carry chain on a strobe, single-field bump on an inc edge in set mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hrs  <= 6'd12;
            r_mins <= 6'd0;
            r_secs <= 6'd0;
            r_ampm <= 1'b0;
        end else if (w_strobe) begin
            r_secs <= w_secs_next;
            if (w_secs_wrap) begin
                r_mins <= w_mins_next;
                if (w_mins_wrap) begin
                    r_hrs <= w_hrs_next;
                    if (w_ampm_flip) begin
                        r_ampm <= ~r_ampm;
                    end
                end
            end
        end else if (set_en && w_inc_pulse) begin
            case (set_sel)
                SEL_HRS: begin
                    r_hrs <= w_hrs_next;
                    if (w_ampm_flip) begin
                        r_ampm <= ~r_ampm;
                    end
                end
                SEL_MINS: r_mins <= w_mins_next;
                SEL_SECS: r_secs <= w_secs_next;
                default: ;
            endcase
        end
    end

    assign hrs  = r_hrs;
    assign mins = r_mins;
    assign secs = r_secs;
    assign ampm = r_ampm;
    assign tick = r_tick;

endmodule

// File: tb/tb_clock_counter.sv
// Bench for clock_counter with TICKS_PER_SEC=4. The reference model keeps
// time as seconds-of-day (0..86399) and derives the 12-hour display from it.
module tb_clock_counter;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       set_en = 1'b0;
    logic [1:0] set_sel = 2'd3;
    logic       inc = 1'b0;
    logic [5:0] hrs;
    logic [5:0] mins;
    logic [5:0] secs;
    logic       ampm;
    logic       tick;

    clock_counter #(.TICKS_PER_SEC(T)) dut (
        .clk     (clk),
        .rst     (rst),
        .set_en  (set_en),
        .set_sel (set_sel),
        .inc     (inc),
        .hrs     (hrs),
        .mins    (mins),
        .secs    (secs),
        .ampm    (ampm),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;

    // Model state
    int   m_sod;
    int   m_cnt;
    logic m_inc_prev;
    logic m_tick;

    wire [19:0] w_dut = {hrs, mins, secs, ampm, tick};

    function automatic logic [19:0] exp_vec();
        int h24;
        int h12;
        h24 = m_sod / 3600;
        h12 = h24 % 12;
        if (h12 == 0) h12 = 12;
        return {6'(h12), 6'((m_sod / 60) % 60), 6'(m_sod % 60), (h24 >= 12), m_tick};
    endfunction

    function automatic int field_val(input logic [1:0] sel);
        if (sel == 2'd0) return m_sod / 3600;
        if (sel == 2'd1) return (m_sod / 60) % 60;
        return m_sod % 60;
    endfunction

    function automatic void model_reset();
        m_sod      = 0;
        m_cnt      = 0;
        m_inc_prev = 1'b0;
        m_tick     = 1'b0;
    endfunction

    // One clock edge of the model. Hours bump in 24-hour terms is simply +1
    // mod 24, which reproduces 12->1 (same half) and 11->12 (half toggles).
    function automatic void model_edge(input logic se, input logic [1:0] sel, input logic i);
        int h24;
        int m;
        int s;
        m_tick = 1'b0;
        if (se) begin
            m_cnt = 0;
            if (i && !m_inc_prev) begin
                h24 = m_sod / 3600;
                m   = (m_sod / 60) % 60;
                s   = m_sod % 60;
                case (sel)
                    2'd0: m_sod = ((h24 + 1) % 24) * 3600 + m * 60 + s;
                    2'd1: m_sod = h24 * 3600 + ((m + 1) % 60) * 60 + s;
                    2'd2: m_sod = h24 * 3600 + m * 60 + (s + 1) % 60;
                    default: ;
                endcase
            end
        end else begin
            m_cnt++;
            if (m_cnt == T) begin
                m_cnt  = 0;
                m_sod  = (m_sod + 1) % 86400;
                m_tick = 1'b1;
            end
        end
        m_inc_prev = i;
    endfunction

    task automatic step(input logic se, input logic [1:0] sel, input logic i);
        set_en  = se;
        set_sel = sel;
        inc     = i;
        @(posedge clk);
        model_edge(se, sel, i);
        #1;
    endtask

    task automatic set_field(input logic [1:0] sel, input int target);
        for (int k = 0; k < 60; k++) begin
            if (field_val(sel) == target) break;
            step(1'b1, sel, 1'b1);
            step(1'b1, sel, 1'b0);
        end
    endtask

    task automatic test_reset();
        set_en = 1'b0; set_sel = 2'd3; inc = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (w_dut !== {6'd12, 6'd0, 6'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", w_dut, {6'd12, 6'd0, 6'd0, 1'b0, 1'b0});
        end
        #1;
        rst = 1'b0;
    endtask

    task automatic test_run();
        int n_ticks = 0;
        int first = -1;
        int last = -1;
        for (int c = 1; c <= 12; c++) begin
            step(1'b0, 2'd3, 1'b0);
            n_tests++;
            if (w_dut !== exp_vec()) begin
                n_fail++;
                $display("FAIL run_cycle %0d: got %h expected %h", c, w_dut, exp_vec());
            end
            if (tick === 1'b1) begin
                n_ticks++;
                if (first < 0) first = c;
                last = c;
            end
        end
        n_tests++;
        if (w_dut[19:1] !== {6'd12, 6'd0, 6'd3, 1'b0} || n_ticks != 3 || last - first != 8) begin
            n_fail++;
            $display("FAIL run_12_cycles: got time %h ticks %0d span %0d expected time %h ticks 3 span 8",
                     w_dut[19:1], n_ticks, last - first, {6'd12, 6'd0, 6'd3, 1'b0});
        end
    endtask

    task automatic test_set_rollover();
        int n_ticks = 0;
        step(1'b1, 2'd3, 1'b0);
        set_field(2'd0, 11);
        set_field(2'd1, 59);
        set_field(2'd2, 59);
        n_tests++;
        if (w_dut !== {6'd11, 6'd59, 6'd59, 1'b0, 1'b0} || w_dut !== exp_vec()) begin
            n_fail++;
            $display("FAIL set_11_59_59: got %h expected %h", w_dut, {6'd11, 6'd59, 6'd59, 1'b0, 1'b0});
        end
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 2'd3, 1'b0);
            if (tick === 1'b1) n_ticks++;
        end
        n_tests++;
        if (w_dut !== {6'd12, 6'd0, 6'd0, 1'b1, 1'b1} || n_ticks != 1) begin
            n_fail++;
            $display("FAIL am_to_pm: got %h ticks %0d expected %h ticks 1",
                     w_dut, n_ticks, {6'd12, 6'd0, 6'd0, 1'b1, 1'b1});
        end
    endtask

    task automatic test_hour_rollovers();
        step(1'b1, 2'd3, 1'b0);
        set_field(2'd1, 59);
        set_field(2'd2, 59);
        for (int c = 0; c < 4; c++) step(1'b0, 2'd3, 1'b0);
        n_tests++;
        if (w_dut !== {6'd1, 6'd0, 6'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL pm_12_to_1: got %h expected %h", w_dut, {6'd1, 6'd0, 6'd0, 1'b1, 1'b1});
        end
        step(1'b1, 2'd3, 1'b0);
        set_field(2'd0, 23);
        set_field(2'd1, 59);
        set_field(2'd2, 59);
        n_tests++;
        if (w_dut !== {6'd11, 6'd59, 6'd59, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL set_11pm: got %h expected %h", w_dut, {6'd11, 6'd59, 6'd59, 1'b1, 1'b0});
        end
        for (int c = 0; c < 4; c++) step(1'b0, 2'd3, 1'b0);
        n_tests++;
        if (w_dut !== {6'd12, 6'd0, 6'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL pm_to_am: got %h expected %h", w_dut, {6'd12, 6'd0, 6'd0, 1'b0, 1'b1});
        end
    endtask

    task automatic test_inc_hold();
        logic [5:0] h0;
        step(1'b1, 2'd1, 1'b0);
        set_field(2'd1, 58);
        h0 = hrs;
        for (int c = 0; c < 10; c++) step(1'b1, 2'd1, 1'b1);
        n_tests++;
        if (mins !== 6'd59 || hrs !== h0 || w_dut !== exp_vec()) begin
            n_fail++;
            $display("FAIL inc_hold: got mins %0d hrs %0d expected mins 59 hrs %0d", mins, hrs, h0);
        end
        step(1'b1, 2'd1, 1'b0);
        step(1'b1, 2'd1, 1'b1);
        n_tests++;
        if (mins !== 6'd0 || hrs !== h0 || w_dut !== exp_vec()) begin
            n_fail++;
            $display("FAIL mins_wrap_no_carry: got mins %0d hrs %0d expected mins 0 hrs %0d", mins, hrs, h0);
        end
    endtask

    task automatic test_no_change();
        logic [19:0] v0;
        step(1'b1, 2'd3, 1'b0);
        v0 = w_dut;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 2'd3, 1'b1);
            step(1'b1, 2'd3, 1'b0);
        end
        n_tests++;
        if (w_dut !== v0 || w_dut !== exp_vec()) begin
            n_fail++;
            $display("FAIL sel_none: got %h expected %h", w_dut, v0);
        end
        for (int c = 0; c < 16; c++) begin
            step(1'b0, 2'($urandom_range(0, 3)), c[0]);
            n_tests++;
            if (w_dut !== exp_vec()) begin
                n_fail++;
                $display("FAIL inc_in_run cycle %0d: got %h expected %h", c, w_dut, exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 2'd3, 1'b0);
        set_field(2'd0, 17);
        set_field(2'd1, 17);
        set_field(2'd2, 41);
        for (int c = 0; c < 4; c++) step(1'b0, 2'd3, 1'b0);
        n_tests++;
        if (w_dut !== {6'd5, 6'd17, 6'd42, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL pre_reset_time: got %h expected %h", w_dut, {6'd5, 6'd17, 6'd42, 1'b1, 1'b1});
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (w_dut !== {6'd12, 6'd0, 6'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", w_dut, {6'd12, 6'd0, 6'd0, 1'b0, 1'b0});
        end
        set_en = 1'b1; set_sel = 2'd0; inc = 1'b1;
        #2;
        rst = 1'b0;
        step(1'b1, 2'd0, 1'b1);
        n_tests++;
        if (w_dut !== {6'd1, 6'd0, 6'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL inc_through_reset: got %h expected %h", w_dut, {6'd1, 6'd0, 6'd0, 1'b0, 1'b0});
        end
        step(1'b1, 2'd0, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            step(1'b0, 2'd3, 1'b0);
            n_tests++;
            if (w_dut !== exp_vec() || tick !== (c == 4)) begin
                n_fail++;
                $display("FAIL first_second_after_set cycle %0d: got %h expected %h", c, w_dut, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                #2;
                rst = 1'b1;
                model_reset();
                #2;
                rst = 1'b0;
            end
            step(($urandom_range(0, 9) < 4), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            n_tests++;
            if (w_dut !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h expected %h", c, w_dut, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_run();
        test_set_rollover();
        test_hour_rollovers();
        test_inc_hold();
        test_no_change();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
